mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum ACCESS-state cycles allowed before an abort (used only when the Configuration macro is defined).
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-low (asserted at 0).
- if_req  input  1  instruction-fetch request; held until if_done.
- if_addr  input  32  fetch address, always a word read.
- if_gnt  output  1  one-cycle pulse: fetch request accepted.
- if_done  output  1  one-cycle pulse: fetch complete, rdata valid.
- d_req  input  1  data (load/store) request; held until d_done.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_done  output  1  one-cycle pulse: data access complete.
- rdata  output  32  last read data returned to either requester.
- ram_addr  output  32  RAM address.
- ram_wdata  output  32  RAM write data.
- ram_size  output  2  RAM access size.
- cs, we, oe  output  1 each  RAM chip select, write enable, output enable.
- ram_rdata  input  32  RAM read data.
- ram_ready  input  1  RAM access complete this cycle.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  sticky timeout flag.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, ACCESS, TURN.
REQ-004 IDLE: on an edge with at least one request high, the FSM SHALL pick a winner and latch its addr, wdata, size and we (fetch: we=0, size=10); SHALL move to ACCESS; SHALL pulse the winner's gnt during the first ACCESS cycle.
REQ-005 Arbitration SHALL be round-robin. With a single request, that request wins. With both high, the requester not granted last wins. The last-winner register SHALL update on every grant.
REQ-006 ACCESS: cs=1, we=latched we, oe=~latched we, and ram_addr/ram_wdata/ram_size SHALL hold the latched values stably.
REQ-007 ACCESS, edge with ram_ready=1: on a read, rdata SHALL capture ram_rdata; on a write, rdata SHALL be unchanged. The winner's done SHALL pulse during the next cycle, and the FSM SHALL go to TURN.
REQ-008 TURN SHALL last exactly one cycle with cs=we=oe=0, then the FSM SHALL return to IDLE. Requests are ignored in TURN.
REQ-009 Minimum latency SHALL be: req sampled at edge N, gnt and cs in cycle N+1, ready at edge N+1 gives done in cycle N+2, next grant no earlier than edge N+3.
REQ-010 A req deasserted during ACCESS SHALL NOT abort the access; it completes and done still pulses.
REQ-011 Outside ACCESS, cs, we and oe SHALL be 0. gnt and done SHALL never be high for both requesters in the same cycle.

Reset
REQ-012 While rst=0, all of the following SHALL hold immediately, including mid-access: state IDLE; all outputs 0 (rdata=32'h0, ram_* = 0, err=0); last-winner = data, so fetch wins the first conflict; timeout counter 0.

Configuration
REQ-013 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ram_ready. On reaching TIMEOUT_CYCLES, err SHALL set (sticky until reset), the winner's done SHALL pulse with rdata unchanged, and the FSM SHALL go to TURN.
REQ-014 Macro undefined: ACCESS SHALL wait indefinitely, and err SHALL be constant 0.

Structure
REQ-015 Package mem_arb_pkg SHALL hold the state encoding, requester IDs (REQ_IF=0, REQ_D=1), size encodings and the TIMEOUT_CYCLES default.
REQ-016 Sub-module mem_arb_rr SHALL implement the combinational round-robin pick from two requests plus the last-winner bit.

Verification
REQ-017 Fetch only: if_req=1, if_addr=32'h100, ram_ready high in first ACCESS cycle, ram_rdata=32'hE3A00001 -> if_gnt in cycle 1, if_done in cycle 2, rdata=32'hE3A00001, cs low in TURN.
REQ-018 Simultaneous after reset: both req high -> fetch granted first, then data. Repeat with both held -> grants alternate D, IF, D.
REQ-019 Store: d_we=1, d_addr=32'h200, d_wdata=32'hCAFEF00D, d_size=00, ready after 3 cycles -> we=1, oe=0 for 3 ACCESS cycles, ram_size=00, d_done one cycle later, rdata unchanged.
REQ-020 Reset asserted mid-ACCESS -> cs=0, busy=0 immediately. After release with no req, no gnt or done appears.
REQ-021 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ram_ready held 0 -> done after 4 ACCESS cycles, err=1 and stays 1. The next request is still serviced normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // The reserved size code is issued to the RAM as a plain word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_RSVD) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes, RAM port and status of the memory port arbiter.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [1:0]  ram_size;
    logic        cs;
    logic        we;
    logic        oe;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        busy;
    logic        err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, ram_rdata, ram_ready,
        output if_gnt, if_done, d_gnt, d_done, rdata, ram_addr, ram_wdata, ram_size,
               cs, we, oe, busy, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, ram_rdata, ram_ready,
        input  if_gnt, if_done, d_gnt, d_done, rdata, ram_addr, ram_wdata, ram_size,
               cs, we, oe, busy, err
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone request wins, a conflict goes to the
// requester that did not win last time.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
    input  req_id_t last_winner,
    output logic    any_req,
    output req_id_t winner
);
    always_comb begin
        any_req = if_req | d_req;
        winner  = REQ_IF;
        if (if_req && d_req) begin
            winner = (last_winner == REQ_IF) ? REQ_D : REQ_IF;
        end else if (d_req) begin
            winner = REQ_D;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-port RAM with a one-cycle bus turnaround.
// Define MEM_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES and raise err.
//
// state     | meaning
// ST_IDLE   | waiting for a request; arbitrates and latches the winner
// ST_ACCESS | RAM cycle in progress for the latched owner
// ST_TURN   | one idle cycle with chip select low; owner's done pulses
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t  state;
    req_id_t     last_winner;
    req_id_t     owner;
    req_id_t     winner;
    logic        any_req;
    logic        access_end;
    logic        if_gnt_q, d_gnt_q, if_done_q, d_done_q;
    logic        cs_q, we_q, oe_q;
    logic [31:0] rdata_q, addr_q, wdata_q;
    logic [1:0]  size_q;

    mem_arb_rr u_rr (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .last_winner (last_winner),
        .any_req     (any_req),
        .winner      (winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned      TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
    assign bus.err = err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        access_end = 1'b0;
        if (state == ST_ACCESS) begin
            access_end = bus.ram_ready;
`ifdef MEM_ARB_TIMEOUT_EN
            if (tmo_cnt == TMO_LAST) access_end = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            last_winner <= REQ_D;
            owner       <= REQ_IF;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if_gnt_q  <= 1'b0;
            d_gnt_q   <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state       <= ST_ACCESS;
                        owner       <= winner;
                        last_winner <= winner;
                        if_gnt_q    <= (winner == REQ_IF);
                        d_gnt_q     <= (winner == REQ_D);
                        cs_q        <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                        if (winner == REQ_IF) begin
                            addr_q  <= bus.if_addr;
                            wdata_q <= '0;
                            size_q  <= SIZE_WORD;
                            we_q    <= 1'b0;
                            oe_q    <= 1'b1;
                        end else begin
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                            size_q  <= norm_size(bus.d_size);
                            we_q    <= bus.d_we;
                            oe_q    <= !bus.d_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (access_end) begin
                        state     <= ST_TURN;
                        cs_q      <= 1'b0;
                        we_q      <= 1'b0;
                        oe_q      <= 1'b0;
                        if_done_q <= (owner == REQ_IF);
                        d_done_q  <= (owner == REQ_D);
                        // rdata only moves on a completed read; aborts and stores leave it alone
                        if (bus.ram_ready && !we_q) rdata_q <= bus.ram_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        if (!bus.ram_ready) err_q <= 1'b1;
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_size  = size_q;
    assign bus.cs        = cs_q;
    assign bus.we        = we_q;
    assign bus.oe        = oe_q;
    assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants/completions,
// a monitor pops and compares them whenever the arbiter pulses gnt or done.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO    = 4;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 255;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        req_id_t     id;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        we;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        req_id_t     id;
        logic [31:0] rdata;
        logic        err;
    } done_exp_t;

    gnt_exp_t    gq[$];
    done_exp_t   dq[$];
    int          checks   = 0;
    int          failures = 0;
    int          ram_lat  = 0;
    int          acc_cyc  = 0;
    logic [31:0] rd_val   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic exp_gnt(input req_id_t id, input logic [31:0] addr, input logic [1:0] size,
                           input logic we, input logic [31:0] wdata);
        gnt_exp_t g;
        g.id = id; g.addr = addr; g.size = size; g.we = we; g.wdata = wdata;
        gq.push_back(g);
    endtask

    task automatic exp_done(input req_id_t id, input logic [31:0] rdata, input logic err);
        done_exp_t d;
        d.id = id; d.rdata = rdata; d.err = err;
        dq.push_back(d);
    endtask

    // Waits for the given requester's done, checking we/oe on every ACCESS cycle seen.
    task automatic wait_done(input req_id_t id, input logic exp_we, input int max_cyc, output int acc);
        bit seen = 1'b0;
        acc = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.cs) begin
                acc++;
                check("access_we", 32'(bus.we), 32'(exp_we));
                check("access_oe", 32'(bus.oe), 32'(!exp_we));
            end
            if ((id == REQ_IF) ? bus.if_done : bus.d_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done_%0d: got no done in %0d cycles expected done", id, max_cyc);
        end
    endtask

    task automatic wait_gnt(input req_id_t id, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if ((id == REQ_IF) ? bus.if_gnt : bus.d_gnt) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_gnt_%0d: got no gnt in %0d cycles expected gnt", id, max_cyc);
        end
    endtask

    // RAM model: ready during the ram_lat-th ACCESS cycle (never when ram_lat is 0).
    initial begin
        bus.ram_ready = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(negedge clk);
            bus.ram_rdata = rd_val;
            if (bus.cs) begin
                acc_cyc++;
                bus.ram_ready = (ram_lat != 0) && (acc_cyc == ram_lat);
            end else begin
                acc_cyc       = 0;
                bus.ram_ready = 1'b0;
            end
        end
    end

    initial begin
        gnt_exp_t  g;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (bus.if_gnt || bus.d_gnt) begin
                check("gnt_exclusive", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
                if (gq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_gnt: got if_gnt=%0b d_gnt=%0b expected none", bus.if_gnt, bus.d_gnt);
                end else begin
                    g = gq.pop_front();
                    check("gnt_id", 32'(bus.d_gnt), 32'(g.id));
                    check("gnt_cs", 32'(bus.cs), 32'd1);
                    check("gnt_addr", bus.ram_addr, g.addr);
                    check("gnt_size", 32'(bus.ram_size), 32'(g.size));
                    check("gnt_we", 32'(bus.we), 32'(g.we));
                    check("gnt_oe", 32'(bus.oe), 32'(!g.we));
                    if (g.we) check("gnt_wdata", bus.ram_wdata, g.wdata);
                end
            end
            if (bus.if_done || bus.d_done) begin
                check("done_exclusive", 32'(bus.if_done & bus.d_done), 32'd0);
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got if_done=%0b d_done=%0b expected none", bus.if_done, bus.d_done);
                end else begin
                    d = dq.pop_front();
                    check("done_id", 32'(bus.d_done), 32'(d.id));
                    check("done_rdata", bus.rdata, d.rdata);
                    check("done_err", 32'(bus.err), 32'(d.err));
                    check("done_cs_low", 32'(bus.cs), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int acc;
        int n;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_size  = '0;

        // Reset values
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cs_we_oe", 32'({bus.cs, bus.we, bus.oe}), 32'd0);
        check("rst_pulses", 32'({bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done}), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_ram_addr", bus.ram_addr, 32'h0);
        check("rst_ram_wdata", bus.ram_wdata, 32'h0);
        check("rst_ram_size", 32'(bus.ram_size), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch only, ready in the first ACCESS cycle: exact latency
        ram_lat = 1;
        rd_val  = 32'hE3A00001;
        @(posedge clk);
        #1;
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        exp_gnt(REQ_IF, 32'h100, SIZE_WORD, 1'b0, 32'h0);
        exp_done(REQ_IF, 32'hE3A00001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("t1_gnt_cycle1", 32'(bus.if_gnt), 32'd1);
        check("t1_cs_cycle1", 32'(bus.cs), 32'd1);
        check("t1_busy_cycle1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("t1_done_cycle2", 32'(bus.if_done), 32'd1);
        check("t1_turn_cs", 32'(bus.cs), 32'd0);
        check("t1_turn_busy", 32'(bus.busy), 32'd1);
        check("t1_rdata", bus.rdata, 32'hE3A00001);
        bus.if_req = 1'b0;
        @(negedge clk);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        // Byte store, ready on the third ACCESS cycle; rdata must keep the fetch value
        ram_lat     = 3;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'hCAFEF00D;
        bus.d_size  = SIZE_BYTE;
        bus.d_req   = 1'b1;
        exp_gnt(REQ_D, 32'h200, SIZE_BYTE, 1'b1, 32'hCAFEF00D);
        exp_done(REQ_D, 32'hE3A00001, 1'b0);
        wait_done(REQ_D, 1'b1, 20, acc);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        check("t3_access_cycles", acc, 32'd3);
        @(negedge clk);

        // Load with reserved size goes out as a word
        ram_lat    = 2;
        rd_val     = 32'hA5A50003;
        bus.d_addr = 32'h300;
        bus.d_size = SIZE_RSVD;
        bus.d_req  = 1'b1;
        exp_gnt(REQ_D, 32'h300, SIZE_WORD, 1'b0, 32'h0);
        exp_done(REQ_D, 32'hA5A50003, 1'b0);
        wait_done(REQ_D, 1'b0, 20, acc);
        bus.d_req = 1'b0;
        check("t_rsvd_access_cycles", acc, 32'd2);
        @(negedge clk);

        // Reset in the middle of a stalled access
        ram_lat     = 0;
        bus.if_addr = 32'h600;
        bus.if_req  = 1'b1;
        exp_gnt(REQ_IF, 32'h600, SIZE_WORD, 1'b0, 32'h0);
        wait_gnt(REQ_IF, 10);
        repeat (TMO_EN ? 2 : 300) @(negedge clk);
        check("t4_still_access", 32'({bus.busy, bus.cs}), 32'd3);
        rst        = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check("t4_rst_cs", 32'(bus.cs), 32'd0);
        check("t4_rst_busy", 32'(bus.busy), 32'd0);
        check("t4_rst_oe", 32'(bus.oe), 32'd0);
        check("t4_rst_rdata", bus.rdata, 32'h0);
        check("t4_rst_ram_addr", bus.ram_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_idle_after_rst", 32'(bus.busy), 32'd0);

        // Both held after reset: IF, D, IF, D, IF
        ram_lat     = 1;
        rd_val      = 32'h12345678;
        bus.if_addr = 32'h700;
        bus.d_addr  = 32'h800;
        bus.d_we    = 1'b0;
        bus.d_size  = SIZE_WORD;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                exp_gnt(REQ_IF, 32'h700, SIZE_WORD, 1'b0, 32'h0);
                exp_done(REQ_IF, 32'h12345678, 1'b0);
            end else begin
                exp_gnt(REQ_D, 32'h800, SIZE_WORD, 1'b0, 32'h0);
                exp_done(REQ_D, 32'h12345678, 1'b0);
            end
        end
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            if (bus.if_done || bus.d_done) n++;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        check("t2_done_count", n, 32'd5);
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Stalled halfword load aborts after 4 ACCESS cycles; err sticks, next access is normal
        ram_lat    = 0;
        bus.d_addr = 32'h900;
        bus.d_size = SIZE_HALF;
        bus.d_req  = 1'b1;
        exp_gnt(REQ_D, 32'h900, SIZE_HALF, 1'b0, 32'h0);
        exp_done(REQ_D, 32'h12345678, 1'b1);
        wait_done(REQ_D, 1'b0, 20, acc);
        bus.d_req = 1'b0;
        check("t5_access_cycles", acc, 32'd4);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 32'(bus.err), 32'd1);
        ram_lat     = 1;
        rd_val      = 32'h0BADCAFE;
        bus.if_addr = 32'hA00;
        bus.if_req  = 1'b1;
        exp_gnt(REQ_IF, 32'hA00, SIZE_WORD, 1'b0, 32'h0);
        exp_done(REQ_IF, 32'h0BADCAFE, 1'b1);
        wait_done(REQ_IF, 1'b0, 20, acc);
        bus.if_req = 1'b0;
        check("t5_after_access_cycles", acc, 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("gnt_queue_empty", 32'(gq.size()), 32'd0);
        check("done_queue_empty", 32'(dq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
